// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if
//   Bundles the PS/2 pins and the decoded key-event outputs of ps2_key_tracker.
//   master : the tracker side (samples the PS/2 pins, drives decoded outputs)
//   slave  : the host side (drives the PS/2 pins, consumes decoded outputs)
// Signals:
//   ps2_clk, ps2_data  raw PS/2 lines, asynchronous to the system clock
//   code               last decoded scan code
//   code_valid         one-cycle strobe qualifying code/code_break/code_ext
//   code_break         code was preceded by an F0 prefix
//   code_ext           code was preceded by an E0 prefix
//   key_held           one bit per tracked key, 1 while the key is down
//   parity_err         one-cycle strobe on an odd-parity failure
//   frame_err          one-cycle strobe on a bad stop bit or frame timeout
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 4
);
    logic                ps2_clk;
    logic                ps2_data;
    logic [7:0]          code;
    logic                code_valid;
    logic                code_break;
    logic                code_ext;
    logic [NUM_KEYS-1:0] key_held;
    logic                parity_err;
    logic                frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output code,
        output code_valid,
        output code_break,
        output code_ext,
        output key_held,
        output parity_err,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  code,
        input  code_valid,
        input  code_break,
        input  code_ext,
        input  key_held,
        input  parity_err,
        input  frame_err
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
//   stop), strips E0/F0 prefixes, reports each scan code and keeps a held/
//   released bit per tracked key.
// Ports:
//   sysclk  system clock, the only clock
//   rst_n   asynchronous active-low reset
//   bus     ps2_key_tracker_if.master: raw PS/2 pins in, decoded events out
// Parameters:
//   FILTER_LEN   equal synchronised samples before the filtered PS/2 clock moves
//   TIMEOUT_CYC  sysclk cycles without a sample before a partial frame aborts
//   NUM_KEYS     number of tracked keys
//   KEY_CODES    byte i is the scan code of tracked key i
// Build option:
//   PS2_TYPEMATIC_FILTER_EN  when defined, auto-repeat make codes of a key that
//                            is already held produce no code_valid.
module ps2_key_tracker #(
    parameter int                    FILTER_LEN  = 8,
    parameter int                    TIMEOUT_CYC = 50000,
    parameter int                    NUM_KEYS    = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES   = {8'h1B, 8'h1D, 8'h23, 8'h1C}
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    ps2_key_tracker_if.master     bus
);

    localparam int               TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    // One bit per tracked key whose scan code equals b (duplicates all hit).
    function automatic logic [NUM_KEYS-1:0] key_match(input logic [7:0] b);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            m[i] = (KEY_CODES[i*8 +: 8] == b);
        return m;
    endfunction

    logic                clk_p0, clk_p1;
    logic                dat_p0, dat_p1;
    logic                filt_clk;
    logic [7:0]          filt_cnt;
    logic                sample_ev;

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                par_bit;
    logic [TO_W-1:0]     to_cnt;
    logic                brk_flag, ext_flag;

    logic [7:0]          code_r;
    logic                code_valid_r, code_break_r, code_ext_r;
    logic [NUM_KEYS-1:0] key_held_r;
    logic                parity_err_r, frame_err_r;

    logic                par_ok;
    logic [NUM_KEYS-1:0] hit;
    logic                repeat_make;

    // Stage p0/p1: two-flop synchronisers, then the PS/2 clock glitch filter.
    // filt_cnt counts consecutive samples that disagree with filt_clk.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_p0   <= 1'b1;
            clk_p1   <= 1'b1;
            dat_p0   <= 1'b1;
            dat_p1   <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_p0 <= bus.ps2_clk;
            clk_p1 <= clk_p0;
            dat_p0 <= bus.ps2_data;
            dat_p1 <= dat_p0;
            if (clk_p1 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    // The cycle in which filt_clk is about to fall is the sample event.
    assign sample_ev = filt_clk & ~clk_p1 & (filt_cnt == FILT_LAST);

    assign par_ok = odd_parity_ok(shreg, par_bit);
    assign hit    = key_match(shreg);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeat_make = ~ext_flag & ~brk_flag & (|(hit & key_held_r));
`else
    assign repeat_make = 1'b0;
`endif

    // Frame FSM and decoded outputs; all strobes are registered, so they
    // appear in the cycle after the stop-bit sample.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            to_cnt       <= '0;
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
            code_r       <= '0;
            code_valid_r <= 1'b0;
            code_break_r <= 1'b0;
            code_ext_r   <= 1'b0;
            key_held_r   <= '0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            code_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;

            if (state == IDLE || sample_ev)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (state != IDLE && !sample_ev && to_cnt == TO_LAST) begin
                // Stalled partial frame: abort and drop any pending prefix.
                state       <= IDLE;
                bit_cnt     <= '0;
                brk_flag    <= 1'b0;
                ext_flag    <= 1'b0;
                frame_err_r <= 1'b1;
            end else if (sample_ev) begin
                case (state)
                    IDLE: begin
                        if (!dat_p1) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_p1, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_p1;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!dat_p1) begin
                            // A bad stop bit outranks a parity failure.
                            frame_err_r <= 1'b1;
                            brk_flag    <= 1'b0;
                            ext_flag    <= 1'b0;
                        end else if (!par_ok) begin
                            parity_err_r <= 1'b1;
                            brk_flag     <= 1'b0;
                            ext_flag     <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext_flag <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_flag <= 1'b1;
                        end else begin
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                            if (!repeat_make) begin
                                code_r       <= shreg;
                                code_valid_r <= 1'b1;
                                code_break_r <= brk_flag;
                                code_ext_r   <= ext_flag;
                                if (!ext_flag) begin
                                    for (int i = 0; i < NUM_KEYS; i++)
                                        if (hit[i])
                                            key_held_r[i] <= ~brk_flag;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.code       = code_r;
    assign bus.code_valid = code_valid_r;
    assign bus.code_break = code_break_r;
    assign bus.code_ext   = code_ext_r;
    assign bus.key_held   = key_held_r;
    assign bus.parity_err = parity_err_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//   Scoreboard bench for ps2_key_tracker: each driven PS/2 frame pushes the
//   event it should cause (code / parity error / frame error) and the model's
//   key_held state; a monitor pops and compares every DUT event.
module tb_ps2_key_tracker;

    localparam int FL    = 4;
    localparam int TO    = 400;
    localparam int HALF  = 12;
    localparam int NK    = 4;
    localparam logic [NK*8-1:0] KC = {8'h1B, 8'h1D, 8'h23, 8'h1C};

    localparam int EV_CODE = 0;
    localparam int EV_PERR = 1;
    localparam int EV_FERR = 2;

    typedef struct {
        int          kind;
        logic [7:0]  code;
        logic        brk;
        logic        ext;
        logic [3:0]  held;
    } exp_t;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    ps2_key_tracker_if #(.NUM_KEYS(NK)) bus ();

    ps2_key_tracker #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO),
        .NUM_KEYS    (NK),
        .KEY_CODES   (KC)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_cv   = 0;
    exp_t q[$];

    // Reference model state.
    logic       m_brk  = 1'b0;
    logic       m_ext  = 1'b0;
    logic [3:0] m_held = 4'b0000;
    logic [7:0] m_keys [4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [7:0] c, input logic b, input logic e);
        exp_t x;
        x.kind = kind;
        x.code = c;
        x.brk  = b;
        x.ext  = e;
        x.held = m_held;
        q.push_back(x);
    endtask

    // Expected outcome of one complete frame.
    task automatic model_frame(input logic [7:0] b, input logic par_good, input logic stop);
        logic match_held;
        if (!stop) begin
            m_brk = 1'b0; m_ext = 1'b0;
            push_ev(EV_FERR, 8'h00, 1'b0, 1'b0);
        end else if (!par_good) begin
            m_brk = 1'b0; m_ext = 1'b0;
            push_ev(EV_PERR, 8'h00, 1'b0, 1'b0);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            match_held = 1'b0;
            for (int i = 0; i < 4; i++)
                if (m_keys[i] == b && m_held[i]) match_held = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_ext && !m_brk && match_held) begin
                m_brk = 1'b0; m_ext = 1'b0;
                return;
            end
`endif
            if (!m_ext)
                for (int i = 0; i < 4; i++)
                    if (m_keys[i] == b) m_held[i] = !m_brk;
            push_ev(EV_CODE, b, m_brk, m_ext);
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        tick(HALF);
        bus.ps2_clk = 1'b0;
        tick(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        logic p;
        model_frame(b, !bad_par, stop);
        p = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(stop);
        bus.ps2_data = 1'b1;
        tick(4 * HALF);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() != 0; i++) tick(1);
        chk("drain", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_code"},  bus.code,       0);
        chk({tag, "_cv"},    bus.code_valid, 0);
        chk({tag, "_brk"},   bus.code_break, 0);
        chk({tag, "_ext"},   bus.code_ext,   0);
        chk({tag, "_held"},  bus.key_held,   0);
        chk({tag, "_perr"},  bus.parity_err, 0);
        chk({tag, "_ferr"},  bus.frame_err,  0);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    exp_t mon_e;
    int   mon_kind;
    always @(negedge sysclk) begin
        if (rst_n && (bus.code_valid || bus.parity_err || bus.frame_err)) begin
            chk("excl", 32'($countones({bus.code_valid, bus.parity_err, bus.frame_err})), 1);
            mon_kind = bus.code_valid ? EV_CODE : (bus.parity_err ? EV_PERR : EV_FERR);
            if (bus.code_valid) n_cv++;
            if (q.size() == 0) begin
                chk("unexpected_evt", mon_kind, 99);
            end else begin
                mon_e = q.pop_front();
                chk("ev_kind", mon_kind, mon_e.kind);
                if (mon_e.kind == EV_CODE) begin
                    chk("ev_code", bus.code, mon_e.code);
                    chk("ev_brk",  bus.code_break, mon_e.brk);
                    chk("ev_ext",  bus.code_ext, mon_e.ext);
                end
                chk("ev_held", bus.key_held, mon_e.held);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cv0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(5);
        chk_zero("rst");
        rst_n = 1'b1;
        tick(10);

        // Plain make, then break via F0.
        ps2_frame(8'h1D, 1'b0, 1'b1);
        drain();
        tick(50);
        chk("code_hold", bus.code, 8'h1D);
        ps2_frame(8'hF0, 1'b0, 1'b1);
        ps2_frame(8'h1D, 1'b0, 1'b1);
        drain();

        // Parity error leaves key_held alone.
        ps2_frame(8'h1B, 1'b0, 1'b1);
        ps2_frame(8'h1C, 1'b1, 1'b1);
        drain();

        // Bad stop bit, and bad stop plus bad parity.
        ps2_frame(8'h23, 1'b0, 1'b0);
        ps2_frame(8'h23, 1'b1, 1'b0);
        drain();

        // An error drops a pending F0: the next 23 is a make.
        ps2_frame(8'hF0, 1'b0, 1'b1);
        ps2_frame(8'h1D, 1'b1, 1'b1);
        ps2_frame(8'h23, 1'b0, 1'b1);
        ps2_frame(8'hF0, 1'b0, 1'b1);
        ps2_frame(8'h23, 1'b0, 1'b1);
        drain();

        // Timeout after five data bits, then a clean frame.
        push_ev(EV_FERR, 8'h00, 1'b0, 1'b0);
        m_brk = 1'b0; m_ext = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        tick(TO + 60);
        drain();
        ps2_frame(8'h23, 1'b0, 1'b1);
        drain();
        chk("held_w", bus.key_held[1], 1);

        // Extended codes never touch key_held.
        ps2_frame(8'hE0, 1'b0, 1'b1);
        ps2_frame(8'h1C, 1'b0, 1'b1);
        ps2_frame(8'hE0, 1'b0, 1'b1);
        ps2_frame(8'h1D, 1'b0, 1'b1);
        drain();
        chk("ext_held0", bus.key_held[0], 0);

        // Short ps2_clk low glitch with data low must not start a frame.
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        tick(FL - 1);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(TO + 100);
        ps2_frame(8'h1C, 1'b0, 1'b1);
        drain();

        // Same make twice.
        cv0 = n_cv;
        ps2_frame(8'h1D, 1'b0, 1'b1);
        ps2_frame(8'h1D, 1'b0, 1'b1);
        drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("dup_cv", n_cv - cv0, 1);
`else
        chk("dup_cv", n_cv - cv0, 2);
`endif

        // Reset in the middle of a frame.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        bus.ps2_data = 1'b1;
        tick(HALF);
        bus.ps2_clk = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(5);
        chk_zero("rst_mid");
        bus.ps2_clk = 1'b1;
        tick(5);
        rst_n  = 1'b1;
        m_held = 4'b0000;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        tick(TO + 60);
        ps2_frame(8'h1D, 1'b0, 1'b1);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter FILTER_LEN, default 8, meaning: consecutive equal sysclk samples needed before the filtered PS/2 clock changes (range 2..255).
REQ-002 Parameter TIMEOUT_CYC, default 50000, meaning: sysclk cycles without a filtered falling edge before a partial frame is aborted.
REQ-003 Parameter NUM_KEYS, default 4, meaning: number of tracked keys (range 1..16).
REQ-004 Parameter KEY_CODES, width NUM_KEYS*8, default {8'h1B,8'h1D,8'h23,8'h1C}, meaning: byte i is the tracked scan code for key i (default order A, D, W, S).
REQ-005 sysclk  input  1  system clock; the only clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ps2_clk  input  1  raw PS/2 clock, asynchronous to sysclk.
REQ-008 ps2_data  input  1  raw PS/2 data, asynchronous to sysclk.
REQ-009 code  output  8  last decoded scan code.
REQ-010 code_valid  output  1  one-cycle pulse; code, code_break and code_ext are valid.
REQ-011 code_break  output  1  code was preceded by F0.
REQ-012 code_ext  output  1  code was preceded by E0.
REQ-013 key_held  output  NUM_KEYS  bit i = key i is currently held.
REQ-014 parity_err  output  1  one-cycle pulse on odd-parity failure.
REQ-015 frame_err  output  1  one-cycle pulse on bad stop bit or timeout.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser.
REQ-017 The filtered clock SHALL change only after FILTER_LEN consecutive equal synchronised samples; it resets to 1.
REQ-018 A sample event SHALL be one sysclk cycle in which the filtered clock goes 1->0; ps2_data (synchronised) is sampled in that cycle.
REQ-019 The FSM SHALL have the states IDLE, DATA, PARITY and STOP; in IDLE, a sample with data=0 SHALL go to DATA, and a sample with data=1 SHALL be ignored.
REQ-020 DATA SHALL shift 8 bits LSB first with a 3-bit counter, going to PARITY after bit 7; PARITY SHALL go to STOP; STOP SHALL return to IDLE.
REQ-021 Parity SHALL be odd over the 8 data bits plus the parity bit; on mismatch, parity_err SHALL pulse in the cycle after the stop sample and the byte SHALL be discarded.
REQ-022 A stop bit of 0 SHALL pulse frame_err and discard the byte; if parity and stop are both bad, only frame_err SHALL pulse.
REQ-023 Outside IDLE, a timeout counter SHALL count cycles since the last sample event; on reaching TIMEOUT_CYC it SHALL pulse frame_err, return to IDLE and discard the partial byte.
REQ-024 A good byte 8'hE0 SHALL set the ext flag and a good byte 8'hF0 SHALL set the break flag; neither SHALL produce code_valid.
REQ-025 Any other good byte SHALL assert code_valid for exactly one cycle, in the cycle after the stop sample, and SHALL then clear both flags.
REQ-026 With code_valid, code SHALL equal the byte, code_break SHALL equal the break flag and code_ext SHALL equal the ext flag; these outputs hold until the next code_valid.
REQ-027 In the same cycle as code_valid, for every i with code==KEY_CODES[i] and ext flag=0: key_held[i] SHALL be set on make and cleared on break; duplicate entries SHALL all update.
REQ-028 Extended codes SHALL never change key_held.
REQ-029 parity_err or frame_err SHALL clear both prefix flags; key_held SHALL be unchanged.
REQ-030 At most one of code_valid, parity_err and frame_err SHALL be asserted in any cycle.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force: FSM=IDLE, flags=0, counters=0, filtered clock=1, code=0, code_valid=0, code_break=0, code_ext=0, key_held=0, parity_err=0, frame_err=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame with no error pulse; decoding SHALL resume at the next start bit after release.

Configuration
REQ-033 With PS2_TYPEMATIC_FILTER_EN defined, a non-extended make code matching a key whose key_held bit is already 1 SHALL produce no code_valid; the flags still clear.
REQ-034 Without PS2_TYPEMATIC_FILTER_EN defined, every make code SHALL produce code_valid.

Verification
REQ-035 Frame 8'h1D with good parity -> code_valid pulse, code=8'h1D, code_break=0, key_held=4'b0100.
REQ-036 F0 then 1D after REQ-035 -> a single code_valid, code_break=1, key_held=4'b0000.
REQ-037 Frame 8'h1C with a wrong parity bit -> parity_err pulse, no code_valid, key_held unchanged.
REQ-038 Stop after 5 data bits for TIMEOUT_CYC cycles -> frame_err pulse; the next frame 8'h23 decodes with key_held[1]=1.
REQ-039 E0 then 1C -> code_valid, code_ext=1, key_held[0]=0; a ps2_clk low glitch of FILTER_LEN-1 cycles -> no sample event.
REQ-040 1D sent twice -> 2 code_valid pulses without PS2_TYPEMATIC_FILTER_EN, 1 with it; rst_n low mid-frame -> all outputs 0 and no error pulse.
